// File: rtl/data_store_buffer_if.sv
// data_store_buffer_if: core store/load side and memory drain side of the posted-write buffer
interface data_store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ack,
    input  ld_hit, ld_data, full, empty, overflow, mem_req, mem_addr, mem_wdata
  );
  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ack,
    output ld_hit, ld_data, full, empty, overflow, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_store_buffer.sv
// data_store_buffer: posted-write FIFO between core stores and data memory, with store-to-load forwarding
module data_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  data_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, idx;
  logic [CW-1:0]     count;
  logic              overflow_q, enq, deq, hit;
  logic [DATA_W-1:0] fwd;
  assign bus.full      = count == CW'(DEPTH);
  assign bus.empty     = count == '0;
  assign bus.mem_req   = ~bus.empty;
  assign bus.overflow  = overflow_q;
  assign bus.mem_addr  = bus.empty ? '0 : addr_q[rd_ptr];
  assign bus.mem_wdata = bus.empty ? '0 : data_q[rd_ptr];
  assign bus.ld_hit    = hit;
  assign bus.ld_data   = fwd;
  assign enq = bus.st_valid & ~bus.full;
  assign deq = bus.mem_req & bus.mem_ack;
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
      if (bus.st_valid & bus.full) overflow_q <= 1'b1;
    end
  always_ff @(posedge clk)
    if (enq) begin
      addr_q[wr_ptr] <= bus.st_addr;
      data_q[wr_ptr] <= bus.st_data;
    end
  // walk oldest to youngest so the last match (youngest) wins; byte offset ignored
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && ((bus.ld_addr ^ addr_q[idx]) >> 2) == '0) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: directed stimulus checked every cycle against a queue model of the buffer
module tb_data_store_buffer;
  typedef struct {logic [31:0] a; logic [31:0] d;} entry_t;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  int checks = 0;
  int errors = 0;
  entry_t q[$];
  logic m_ovf = 1'b0;
  logic [31:0] drained[$];
  logic [31:0] issued[$];
  data_store_buffer_if bus();
  data_store_buffer dut (.clk(clk), .rst_in(rst_in), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // model: queue of buffered stores, head at index 0
  always @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      q.delete();
      m_ovf <= 1'b0;
    end else begin
      automatic bit was_full = q.size() == 4;
      if (q.size() != 0 && bus.mem_ack) begin
        drained.push_back(q[0].a);
        void'(q.pop_front());
      end
      if (bus.st_valid && !was_full) q.push_back('{bus.st_addr, bus.st_data});
      if (bus.st_valid && was_full) m_ovf <= 1'b1;
    end
  always @(negedge clk) begin
    automatic logic hit = 1'b0;
    automatic logic [31:0] fd = '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[31:2] == bus.ld_addr[31:2]) begin
        hit = 1'b1;
        fd = q[i].d;
        break;
      end
    check("full", 32'(bus.full), 32'(q.size() == 4));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("mem_req", 32'(bus.mem_req), 32'(q.size() != 0));
    check("mem_addr", bus.mem_addr, q.size() != 0 ? q[0].a : 32'h0);
    check("mem_wdata", bus.mem_wdata, q.size() != 0 ? q[0].d : 32'h0);
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("ld_hit", 32'(bus.ld_hit), 32'(hit));
    check("ld_data", bus.ld_data, fd);
  end
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic ack);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.mem_ack  = ack;
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask
  task automatic do_reset();
    rst_in = 1'b0;
    #3;
    rst_in = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.ld_addr  = 32'hFFFF_FFF0;
    bus.mem_ack  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    do_reset();
    // single store held, then acked
    step(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
    check("t1_req", 32'(bus.mem_req), 32'h1);
    check("t1_addr", bus.mem_addr, 32'h100);
    check("t1_data", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t1_empty", 32'(bus.empty), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0);
      check("t1_hold_addr", bus.mem_addr, 32'h100);
      check("t1_hold_data", bus.mem_wdata, 32'hDEAD_BEEF);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("t1_done_empty", 32'(bus.empty), 32'h1);
    check("t1_done_req", 32'(bus.mem_req), 32'h0);
    // fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    check("t2_full", 32'(bus.full), 32'h1);
    step(1'b1, 32'h10, 32'hBAD, 1'b0);
    check("t2_ovf", 32'(bus.overflow), 32'h1);
    check("t2_still_full", 32'(bus.full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_addr", bus.mem_addr, 32'(4 * i));
      check("t2_drain_data", bus.mem_wdata, 32'hA0 + 32'(i));
      step(1'b0, 32'h0, 32'h0, 1'b1);
    end
    check("t2_empty", 32'(bus.empty), 32'h1);
    check("t2_ovf_sticky", 32'(bus.overflow), 32'h1);
    // store while full with ack in same cycle is dropped
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(4 * i), 32'(i), 1'b0);
    step(1'b1, 32'h50, 32'h55, 1'b1);
    check("t3_ovf", 32'(bus.overflow), 32'h1);
    check("t3_full", 32'(bus.full), 32'h0);
    check("t3_head", bus.mem_addr, 32'h44);
    // forwarding, youngest wins, word granular
    do_reset();
    step(1'b1, 32'h20, 32'h11, 1'b0);
    step(1'b1, 32'h20, 32'h22, 1'b0);
    bus.ld_addr = 32'h22;
    #1;
    check("t4_hit", 32'(bus.ld_hit), 32'h1);
    check("t4_data", bus.ld_data, 32'h22);
    bus.ld_addr = 32'h24;
    #1;
    check("t4_miss", 32'(bus.ld_hit), 32'h0);
    check("t4_miss_data", bus.ld_data, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    bus.ld_addr = 32'h20;
    #1;
    check("t4_after_ack", bus.ld_data, 32'h22);
    bus.ld_addr = 32'hFFFF_FFF0;
    // wrap-around with random acks; core stalls on full
    do_reset();
    drained.delete();
    issued.delete();
    for (int c = 0; c < 200 && (issued.size() < 10 || q.size() != 0); c++) begin
      automatic logic v = issued.size() < 10 && q.size() < 4;
      automatic logic [31:0] a = 32'h300 + 32'(4 * issued.size());
      if (v) issued.push_back(a);
      step(v, a, ~a, 1'($urandom_range(0, 1)));
    end
    check("t5_count", 32'(drained.size()), 32'd10);
    for (int i = 0; i < 10 && i < drained.size(); i++) check("t5_order", drained[i], 32'h300 + 32'(4 * i));
    check("t5_ovf", 32'(bus.overflow), 32'h0);
    // async reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80 + 32'(4 * i), 32'(i), 1'b0);
    check("t6_req_before", 32'(bus.mem_req), 32'h1);
    #1;
    rst_in = 1'b0;
    #1;
    check("t6_req", 32'(bus.mem_req), 32'h0);
    check("t6_empty", 32'(bus.empty), 32'h1);
    check("t6_ovf", 32'(bus.overflow), 32'h0);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h200, 32'h1234, 1'b0);
    check("t6_first", bus.mem_addr, 32'h200);
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_drained", 32'(bus.empty), 32'h1);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
